// File: rtl/cov_accumulator.sv
// cov_accumulator: streaming 4x4 covariance estimator over N = 2^LOG2N samples.
// A single time-shared 64x64 multiplier produces the 10 unique products of
// each sample vector, one per cycle. A per-entry accumulator lane sums them,
// and each lane registers its averaged, saturated C entry when the estimate
// completes.

// One upper-triangle entry: accumulator plus registered averaged output.
module cov_acc_lane #(
  parameter int LOG2N = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        load,
  input  logic [63:0] prod,
  output logic [63:0] c
);
  localparam int AW = 64 + LOG2N;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic signed [AW-1:0] acc, acc_nxt, acc_avg, prod_ext;
  logic                 ovf;
  logic [63:0]          c_sat;

  assign prod_ext = {{LOG2N{prod[63]}}, prod};
  assign acc_nxt  = en ? acc + prod_ext : acc;
  // The average is taken from acc_nxt so the final product lands in C on the same edge.
  assign acc_avg  = acc_nxt >>> LOG2N;
  assign ovf      = !((&acc_avg[AW-1:63]) || !(|acc_avg[AW-1:63]));
  assign c_sat    = ovf ? (acc_avg[AW-1] ? SMIN : SMAX) : acc_avg[63:0];

  // Accumulate the selected product; capture the averaged entry on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      c   <= '0;
    end else begin
      if (clr) acc <= '0;
      else     acc <= acc_nxt;
      if (load) c <= c_sat;
    end
  end
endmodule

module cov_accumulator #(
  parameter int LOG2N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [63:0]      x1,
  input  logic [63:0]      x2,
  input  logic [63:0]      x3,
  input  logic [63:0]      x4,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      C11, C12, C13, C14,
  output logic [63:0]      C21, C22, C23, C24,
  output logic [63:0]      C31, C32, C33, C34,
  output logic [63:0]      C41, C42, C43, C44,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [LOG2N:0]   sample_cnt
);
  localparam int NPAIR = 10;
  localparam logic [LOG2N:0] NS = {1'b1, {LOG2N{1'b0}}};
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t               state, state_nxt;
  logic [3:0]           mac_idx;
  logic [3:0][63:0]     xr;
  logic [1:0]           ia, ib;
  logic                 accept, mac_last, hs;
  logic signed [127:0]  prod_full, prod_sh;
  logic [63:0]          prod;
  logic [NPAIR-1:0][63:0] cpk;

  assign in_ready = (state == IDLE) && !clear;
  assign c_valid  = (state == OUT);
  assign accept   = in_valid && in_ready;
  assign mac_last = (state == MAC) && (mac_idx == 4'd9);
  assign hs       = (state == OUT) && c_ready && !clear;

  // Operand select: upper-triangle pair order (1,1),(1,2)..(4,4).
  always_comb begin
    ia = 2'd0;
    ib = 2'd0;
    case (mac_idx)
      4'd0: begin ia = 2'd0; ib = 2'd0; end
      4'd1: begin ia = 2'd0; ib = 2'd1; end
      4'd2: begin ia = 2'd0; ib = 2'd2; end
      4'd3: begin ia = 2'd0; ib = 2'd3; end
      4'd4: begin ia = 2'd1; ib = 2'd1; end
      4'd5: begin ia = 2'd1; ib = 2'd2; end
      4'd6: begin ia = 2'd1; ib = 2'd3; end
      4'd7: begin ia = 2'd2; ib = 2'd2; end
      4'd8: begin ia = 2'd2; ib = 2'd3; end
      4'd9: begin ia = 2'd3; ib = 2'd3; end
      default: begin ia = 2'd0; ib = 2'd0; end
    endcase
  end

  assign prod_full = $signed({{64{xr[ia][63]}}, xr[ia]}) * $signed({{64{xr[ib][63]}}, xr[ib]});
  assign prod_sh   = prod_full >>> 32;
  assign prod      = ((&prod_sh[127:63]) || !(|prod_sh[127:63])) ? prod_sh[63:0]
                   : (prod_sh[127] ? SMIN : SMAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> MAC (10 cycles) -> OUT on the Nth sample, else IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)   state_nxt = MAC;
      MAC:  if (mac_last) state_nxt = (sample_cnt == NS) ? OUT : IDLE;
      OUT:  if (hs)       state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Sample latch, product index and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr         <= '0;
      mac_idx    <= '0;
      sample_cnt <= '0;
    end else begin
      if (accept) xr <= {x4, x3, x2, x1};
      if (clear || state != MAC || mac_last) mac_idx <= '0;
      else                                   mac_idx <= mac_idx + 4'd1;
      if (clear || hs)  sample_cnt <= '0;
      else if (accept)  sample_cnt <= sample_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NPAIR; g++) begin : g_lane
    cov_acc_lane #(.LOG2N(LOG2N)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear || hs),
      .en   (!clear && state == MAC && mac_idx == 4'(g)),
      .load (!clear && mac_last && sample_cnt == NS),
      .prod (prod),
      .c    (cpk[g])
    );
  end

  assign C11 = cpk[0]; assign C12 = cpk[1]; assign C13 = cpk[2]; assign C14 = cpk[3];
  assign C22 = cpk[4]; assign C23 = cpk[5]; assign C24 = cpk[6];
  assign C33 = cpk[7]; assign C34 = cpk[8]; assign C44 = cpk[9];
  assign C21 = cpk[1]; assign C31 = cpk[2]; assign C41 = cpk[3];
  assign C32 = cpk[5]; assign C42 = cpk[6]; assign C43 = cpk[8];
endmodule

// File: tb/tb_cov_accumulator.sv
// Directed bench for cov_accumulator with LOG2N=2 (N=4).
module tb_cov_accumulator;
  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] TWO  = 64'h0000_0002_0000_0000;
  localparam logic [63:0] THR  = 64'h0000_0003_0000_0000;
  localparam logic [63:0] FOUR = 64'h0000_0004_0000_0000;
  localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] QTR  = 64'h0000_0000_4000_0000;
  localparam logic [63:0] M1   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] M2   = 64'hFFFF_FFFE_0000_0000;
  localparam logic [63:0] MH   = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] BIG  = 64'h0010_0000_0000_0000;
  localparam logic [63:0] NBIG = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, c_ready = 1'b0;
  logic [63:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic in_ready, c_valid;
  logic [2:0] sample_cnt;
  logic [63:0] C11, C12, C13, C14, C21, C22, C23, C24;
  logic [63:0] C31, C32, C33, C34, C41, C42, C43, C44;
  logic [63:0] cm [16];
  logic [63:0] em [16];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  cov_accumulator #(.LOG2N(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .in_valid(in_valid), .in_ready(in_ready),
    .C11(C11), .C12(C12), .C13(C13), .C14(C14),
    .C21(C21), .C22(C22), .C23(C23), .C24(C24),
    .C31(C31), .C32(C32), .C33(C33), .C34(C34),
    .C41(C41), .C42(C42), .C43(C43), .C44(C44),
    .c_valid(c_valid), .c_ready(c_ready), .sample_cnt(sample_cnt)
  );

  assign cm[0]  = C11; assign cm[1]  = C12; assign cm[2]  = C13; assign cm[3]  = C14;
  assign cm[4]  = C21; assign cm[5]  = C22; assign cm[6]  = C23; assign cm[7]  = C24;
  assign cm[8]  = C31; assign cm[9]  = C32; assign cm[10] = C33; assign cm[11] = C34;
  assign cm[12] = C41; assign cm[13] = C42; assign cm[14] = C43; assign cm[15] = C44;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Build the expected symmetric matrix from its upper triangle.
  task automatic fill(input logic [63:0] a11, a12, a13, a14, a22, a23, a24, a33, a34, a44);
    em[0]  = a11; em[1]  = a12; em[2]  = a13; em[3]  = a14;
    em[4]  = a12; em[5]  = a22; em[6]  = a23; em[7]  = a24;
    em[8]  = a13; em[9]  = a23; em[10] = a33; em[11] = a34;
    em[12] = a14; em[13] = a24; em[14] = a34; em[15] = a44;
  endtask

  task automatic chk_mat(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.C%0d%0d", tag, i / 4 + 1, i % 4 + 1), cm[i], em[i]);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.c_valid", {63'd0, c_valid}, 64'd0);
    chk("rst.cnt", {61'd0, sample_cnt}, 64'd0);
    fill('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    chk_mat("rst");
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);

    // Basic estimate, in_valid held throughout (extra inputs must be ignored)
    x1 = ONE; x2 = TWO; x3 = M1; x4 = HALF; in_valid = 1'b1;
    tick();                                   // edge 0
    chk("b.cnt_e0", {61'd0, sample_cnt}, 64'd1);
    chk("b.ready_mac", {63'd0, in_ready}, 64'd0);
    tick(9);                                  // edge 9
    chk("b.cnt_e9", {61'd0, sample_cnt}, 64'd1);
    tick();                                   // edge 10
    chk("b.ready_e10", {63'd0, in_ready}, 64'd1);
    chk("b.cnt_e10", {61'd0, sample_cnt}, 64'd1);
    tick();                                   // edge 11
    chk("b.cnt_e11", {61'd0, sample_cnt}, 64'd2);
    tick(31);                                 // edge 42
    chk("b.cvalid_e42", {63'd0, c_valid}, 64'd0);
    chk("b.cnt_e42", {61'd0, sample_cnt}, 64'd4);
    tick();                                   // edge 43
    chk("b.cvalid_e43", {63'd0, c_valid}, 64'd1);
    fill(ONE, TWO, M1, HALF, FOUR, M2, ONE, ONE, MH, QTR);
    chk_mat("basic");

    // Backpressure with in_valid still asserted
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp.c_valid", {63'd0, c_valid}, 64'd1);
      chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp.cnt", {61'd0, sample_cnt}, 64'd4);
      chk("bp.C22", C22, FOUR);
      chk("bp.C34", C34, MH);
    end
    c_ready = 1'b1; in_valid = 1'b0;
    tick();
    c_ready = 1'b0;
    chk("hs.c_valid", {63'd0, c_valid}, 64'd0);
    chk("hs.in_ready", {63'd0, in_ready}, 64'd1);
    chk("hs.cnt", {61'd0, sample_cnt}, 64'd0);
    chk_mat("hs_hold");

    // Clear mid-run
    x1 = THR; x2 = THR; x3 = THR; x4 = THR; in_valid = 1'b1;
    tick();                                   // first accept
    tick(11);                                 // second accept
    chk("clr.cnt2", {61'd0, sample_cnt}, 64'd2);
    in_valid = 1'b0;
    tick(3);
    clear = 1'b1;
    #1;
    chk("clr.ready_gated", {63'd0, in_ready}, 64'd0);
    tick();
    chk("clr.cnt0", {61'd0, sample_cnt}, 64'd0);
    // clear wins over in_valid while idle
    x1 = ONE; x2 = ONE; x3 = ONE; x4 = ONE; in_valid = 1'b1;
    tick();
    chk("clr.no_accept", {61'd0, sample_cnt}, 64'd0);
    clear = 1'b0;
    #1;
    chk("clr.ready_back", {63'd0, in_ready}, 64'd1);
    tick(44);                                 // edges 0..43 of fresh estimate
    chk("clr.c_valid", {63'd0, c_valid}, 64'd1);
    fill(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    chk_mat("clr");
    // clear wins over c_ready in OUT; C holds
    in_valid = 1'b0; c_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; c_ready = 1'b0;
    chk("clr_out.c_valid", {63'd0, c_valid}, 64'd0);
    chk("clr_out.cnt", {61'd0, sample_cnt}, 64'd0);
    chk("clr_out.C44", C44, ONE);

    // Saturation
    x1 = BIG; x2 = NBIG; x3 = '0; x4 = '0; in_valid = 1'b1;
    tick(44);
    chk("sat.c_valid", {63'd0, c_valid}, 64'd1);
    fill(SMAX, SMIN, '0, '0, SMAX, '0, '0, '0, '0, '0);
    chk_mat("sat");

    // Reset mid-run while in OUT
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.c_valid", {63'd0, c_valid}, 64'd0);
    chk("mrst.cnt", {61'd0, sample_cnt}, 64'd0);
    fill('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    chk_mat("mrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst.c_valid2", {63'd0, c_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cov_accumulator.md
COV_ACCUMULATOR -- requirements
Module: cov_accumulator

Interface
REQ-001 Parameter LOG2N, default 10, meaning samples per estimate N = 2^LOG2N (range 1..16).
REQ-002 Port clk  input  1  meaning single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-004 Port clear  input  1  meaning synchronous abort: discard the partial estimate.
REQ-005 Ports x1, x2, x3, x4  input  64 each  meaning signed Q32.32 zero-mean sample vector; centering is done upstream.
REQ-006 Port in_valid  input  1  meaning sample vector present.
REQ-007 Port in_ready  output  1  meaning block accepts a sample.
REQ-008 Ports C11..C44  output  64 each (16 ports)  meaning signed Q32.32 covariance matrix; feeds the whitening QR/multiplier stage.
REQ-009 Port c_valid  output  1  meaning C matrix valid.
REQ-010 Port c_ready  input  1  meaning downstream takes C.
REQ-011 Port sample_cnt  output  LOG2N+1  meaning samples accumulated in the current estimate.

Function
REQ-012 States SHALL be IDLE, MAC and OUT; in_ready SHALL equal (state==IDLE && !clear).
REQ-013 A sample SHALL be accepted on an edge with in_valid && in_ready; x1..x4 are latched, sample_cnt increments and the state goes to MAC.
REQ-014 MAC SHALL last exactly 10 cycles and use one 64x64 signed multiplier, one product per cycle, in pair order (1,1),(1,2),(1,3),(1,4),(2,2),(2,3),(2,4),(3,3),(3,4),(4,4).
REQ-015 Each product SHALL be formed as full 128-bit, arithmetic-shifted right by 32, then saturated to the signed 64-bit range.
REQ-016 Each product SHALL be added to its own accumulator: 10 accumulators, each signed 64+LOG2N bits, never overflowing.
REQ-017 After the 10th MAC edge, the state SHALL go to OUT if sample_cnt==N, else to IDLE.
REQ-018 Sample throughput SHALL be one sample per 11 cycles.
REQ-019 In OUT, c_valid SHALL be 1, and C_ij = C_ji = sat64(acc_ij >>> LOG2N), with an arithmetic shift; C SHALL be registered and stable while c_valid=1.
REQ-020 The OUT to IDLE transition SHALL occur on an edge with c_valid && c_ready; on that edge accumulators and sample_cnt clear to 0 and C holds its last value.
REQ-021 c_valid SHALL fall in the cycle after the handshake; the first cycle with c_valid=1 SHALL be the cycle after the 10th MAC edge of sample N.
REQ-022 clear=1 on any edge SHALL zero accumulators and sample_cnt, force IDLE, drop c_valid and leave C unchanged.
REQ-023 clear wins over simultaneous in_valid (no accept) and over c_ready (no handshake counted).
REQ-024 in_valid during MAC or OUT SHALL be ignored, with no sample loss counted.

Reset
REQ-025 rst_n=0 SHALL immediately set state=IDLE, all accumulators=0, sample_cnt=0, c_valid=0, C11..C44=0 and the latched x=0.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-027 Reset during MAC or OUT SHALL discard all partial state, with no output pulse.

Verification (LOG2N=2, N=4; 1.0 = 0x0000_0001_0000_0000)
REQ-028 Scenario reset: rst_n low mid-run -> all C=0, c_valid=0, sample_cnt=0 immediately; in_ready=1 after release.
REQ-029 Scenario basic estimate: 4 back-to-back samples x=(1.0,2.0,-1.0,0.5), first accepted at edge 0 ->
- c_valid=1 in the cycle after edge 43;
- C11=1.0, C12=C21=2.0, C13=-1.0, C14=0.5, C22=4.0, C23=-2.0, C24=1.0, C33=1.0, C34=-0.5, C44=0.25.
REQ-030 Scenario backpressure: hold c_ready=0 for 20 cycles after c_valid -> C stable, c_valid=1, in_ready=0 throughout; c_ready=1 -> next cycle c_valid=0, in_ready=1, sample_cnt=0.
REQ-031 Scenario clear mid-run: 2 samples of (3.0,3.0,3.0,3.0), then clear asserted during MAC, then 4 samples of (1.0,1.0,1.0,1.0) -> all 16 C entries = 1.0.
REQ-032 Scenario saturation: 4 samples x1=1048576.0 (raw 0x0010_0000_0000_0000), x2=-1048576.0, x3=x4=0 ->
- C11=C22=0x7FFF_FFFF_FFFF_FFFF;
- C12=C21=0x8000_0000_0000_0000;
- all other entries 0.
REQ-033 Scenario ignored input: in_valid held 1 during MAC and OUT -> exactly one sample counted per 11 cycles; sample_cnt reaches 4, never 5.
